ram_512x32: RTL and testbench



---
 rtl/ram_512x32.sv | 27 ++
 tb/tb_ram_512x32.sv | 111 +++++++++++
 2 files changed

// File: rtl/ram_512x32.sv
// ram_512x32: simple dual-port RAM (one write, one read port), registered read, read-first by default; RAM_512X32_WR_BYPASS_EN selects write-first
module ram_512x32 #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          c,
    input  logic          rst,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] d,
    input  logic          we
);
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    logic [DW-1:0] rd;
`ifdef RAM_512X32_WR_BYPASS_EN
    assign rd = (we && waddr == raddr) ? d : mem[raddr];
`else
    assign rd = mem[raddr];
`endif
    // array write, suppressed while reset is held
    always_ff @(posedge c)
        if (!rst && we) mem[waddr] <= d;
    // registered read port; reset clears only the output register
    always_ff @(posedge c)
        q <= rst ? '0 : rd;
endmodule

// File: tb/tb_ram_512x32.sv
// tb_ram_512x32: directed and randomized checks of ram_512x32 against an array reference model
module tb_ram_512x32;
`ifdef RAM_512X32_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        c = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  raddr = '0;
    logic [8:0]  waddr = '0;
    logic [31:0] d = '0;
    logic        we = 1'b0;
    logic [31:0] q;
    logic        n_rst = 1'b1;
    logic [3:0]  n_raddr = '0;
    logic [3:0]  n_waddr = '0;
    logic [7:0]  n_d = '0;
    logic        n_we = 1'b0;
    logic [7:0]  n_q;
    logic [4:0]  a5;
    logic [31:0] model [512];
    logic [31:0] exp_q;
    int          n_chk = 0;
    int          n_fail = 0;

    ram_512x32 dut (.c(c), .rst(rst), .raddr(raddr), .q(q), .waddr(waddr), .d(d), .we(we));
    ram_512x32 #(.AW(4), .DW(8)) dut_n (.c(c), .rst(n_rst), .raddr(n_raddr), .q(n_q),
                                        .waddr(n_waddr), .d(n_d), .we(n_we));

    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // one clock edge on the wide DUT; the model predicts q from the rules and then applies the write
    task automatic cyc(input string tag, input logic r, input logic w, input logic [8:0] wa,
                       input logic [31:0] dd, input logic [8:0] ra);
        rst = r; we = w; waddr = wa; d = dd; raddr = ra;
        @(posedge c);
        if (r) exp_q = '0;
        else if (BYP && w && wa == ra) exp_q = dd;
        else exp_q = model[ra];
        if (w && !r) model[wa] = dd;
        #1 check(tag, q, exp_q);
    endtask

    task automatic ncyc(input logic w, input logic [3:0] wa, input logic [7:0] dd, input logic [3:0] ra);
        n_rst = 1'b0; n_we = w; n_waddr = wa; n_d = dd; n_raddr = ra;
        @(posedge c);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model[i] = '0;
        cyc("reset", 1'b1, 1'b0, 9'd0, 32'd0, 9'd0);
        check("reset_q", q, 32'd0);
        cyc("basic_wr", 1'b0, 1'b1, 9'd5, 32'hDEADBEEF, 9'd0);
        cyc("basic_rd", 1'b0, 1'b0, 9'd0, 32'd0, 9'd5);
        check("basic_q", q, 32'hDEADBEEF);
        cyc("unwr_rd", 1'b0, 1'b0, 9'd0, 32'd0, 9'd6);
        check("unwritten_q", q, 32'd0);
        for (int i = 0; i < 512; i++) cyc("stream_wr", 1'b0, 1'b1, 9'(i), 32'(i * 3), 9'd0);
        for (int i = 0; i < 512; i++) begin
            cyc("stream_rd", 1'b0, 1'b0, 9'd0, 32'd0, 9'(i));
            check("stream_q", q, 32'(i * 3));
        end
        check("addr511", q, 32'h5FD);
        cyc("rdw_pre", 1'b0, 1'b1, 9'd7, 32'h11, 9'd0);
        cyc("rdw", 1'b0, 1'b1, 9'd7, 32'h22, 9'd7);
        check("rdw_q", q, BYP ? 32'h22 : 32'h11);
        cyc("rdw_next", 1'b0, 1'b0, 9'd0, 32'd0, 9'd7);
        check("rdw_next_q", q, 32'h22);
        cyc("rst_pre", 1'b0, 1'b1, 9'd3, 32'hA5A5A5A5, 9'd0);
        cyc("rst_rd", 1'b0, 1'b0, 9'd0, 32'd0, 9'd3);
        check("rst_pre_q", q, 32'hA5A5A5A5);
        for (int k = 0; k < 2; k++) begin
            cyc("rst_hold", 1'b1, 1'b1, 9'd3, 32'hFFFFFFFF, 9'd3);
            check("rst_hold_q", q, 32'd0);
        end
        cyc("rst_rel", 1'b0, 1'b0, 9'd0, 32'd0, 9'd3);
        check("rst_kept_q", q, 32'hA5A5A5A5);
        cyc("ind_pre", 1'b0, 1'b1, 9'd200, 32'h12345678, 9'd0);
        for (int k = 1; k <= 10; k++) begin
            cyc("ind", 1'b0, 1'b1, 9'd100, 32'(k), 9'd200);
            check("ind_stable", q, 32'h12345678);
        end
        cyc("ind_rd", 1'b0, 1'b0, 9'd0, 32'd0, 9'd100);
        check("ind_last", q, 32'd10);
        for (int k = 0; k < 3000; k++) begin
            logic [8:0] wa, ra;
            wa = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom);
            ra = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom);
            cyc("rand", $urandom_range(0, 31) == 0, 1'($urandom), wa, $urandom, ra);
        end
        ncyc(1'b1, 4'd0, 8'h77, 4'd0);
        ncyc(1'b1, 4'd15, 8'h3C, 4'd0);
        ncyc(1'b0, 4'd0, 8'h00, 4'd15);
        check("narrow_15", 32'(n_q), 32'h3C);
        a5 = 5'd16;
        ncyc(1'b0, 4'd0, 8'h00, a5[3:0]);
        check("narrow_wrap", 32'(n_q), 32'h77);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
